// File: rtl/input_fifo_pkg.sv
// Shared definitions for the width-converting input FIFO: sizing helper,
// RATIO legality check and sub-word delivery order constants.
package input_fifo_pkg;

  typedef enum logic {
    SUBW_MSB_FIRST = 1'b0,
    SUBW_LSB_FIRST = 1'b1
  } subw_order_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic bit ratio_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4) || (ratio == 8);
  endfunction

endpackage

// File: rtl/input_fifo_wconv_if.sv
// Write/read bus of the width-converting FIFO; slave is the FIFO side,
// master is the producer/consumer side.
interface input_fifo_wconv_if #(
  parameter int IN_WIDTH   = 16,
  parameter int RATIO      = 2,
  parameter int DEPTH_LOG2 = 12
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;

  logic [IN_WIDTH-1:0]  din;
  logic                 wr_en;
  logic                 full;
  logic                 almost_full;
  logic                 prog_full;
  logic [DEPTH_LOG2:0]  wr_count;
  logic                 err_overflow;
  logic                 rd_en;
  logic [OUT_WIDTH-1:0] dout;
  logic                 empty;

  modport slave (
    input  din, wr_en, rd_en,
    output full, almost_full, prog_full, wr_count, err_overflow, dout, empty
  );

  modport master (
    output din, wr_en, rd_en,
    input  full, almost_full, prog_full, wr_count, err_overflow, dout, empty
  );
endinterface

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage with a registered read port, one clock.
module fifo_ram_sdp #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  // NOTE: neither the array nor the read register is reset; a reset here
  // would stop the tools mapping it onto block RAM. Use <= for all state.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/input_fifo_wconv.sv
// Width-converting first-word-fall-through FIFO: IN_WIDTH words in,
// RATIO sub-words of IN_WIDTH/RATIO bits out, one sub-word per accepted read.
module input_fifo_wconv
  import input_fifo_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int RATIO          = 2,
  parameter int DEPTH_LOG2     = 12,
  parameter int PROG_FULL_FREE = 3840,
  parameter int LSB_FIRST      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input_fifo_wconv_if.slave       bus
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int DEPTH     = 2 ** DEPTH_LOG2;
  localparam int SUB_W     = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam bit LSB_ORDER = (LSB_FIRST == int'(SUBW_LSB_FIRST));
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_CNT   = (DEPTH_LOG2+1)'(DEPTH - 1);
  localparam logic [SUB_W-1:0]    LAST_SUB = SUB_W'(RATIO - 1);

  if (!ratio_legal(RATIO) || (IN_WIDTH % RATIO) != 0) begin : g_bad_param
    $error("input_fifo_wconv: RATIO must be 1/2/4/8 and divide IN_WIDTH");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   wr_count, unfetched;
  logic [SUB_W-1:0]      sub_idx;
  logic                  head_valid, err_overflow, full;
  logic [IN_WIDTH-1:0]   head_word;
  logic [OUT_WIDTH-1:0]  subword;
  logic                  wr_accept, rd_accept, retire, fetch;
  int                    k;

  // rd_ptr is the RAM fetch pointer; the fetched head word lives in the
  // RAM read register, which doubles as the fall-through output register.
  fifo_ram_sdp #(.WIDTH(IN_WIDTH), .ADDR_W(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .re    (fetch),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  // NOTE: every always_comb output gets a value on every path so no latch
  // is inferred.
  always_comb begin
    wr_accept = bus.wr_en && !full;
    rd_accept = bus.rd_en && head_valid;
    retire    = rd_accept && (sub_idx == LAST_SUB);
    unfetched = wr_count - {{DEPTH_LOG2{1'b0}}, head_valid};
    fetch     = (unfetched != '0) && (!head_valid || retire);
    k         = LSB_ORDER ? int'(sub_idx) : (RATIO - 1 - int'(sub_idx));
    subword   = OUT_WIDTH'(head_word >> (k * OUT_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_count     <= '0;
      sub_idx      <= '0;
      head_valid   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)     rd_ptr <= rd_ptr + 1'b1;
      if (bus.wr_en && full) err_overflow <= 1'b1;
      case ({wr_accept, retire})
        2'b10:   wr_count <= wr_count + 1'b1;
        2'b01:   wr_count <= wr_count - 1'b1;
        default: ;
      endcase
      if (rd_accept) sub_idx <= retire ? '0 : sub_idx + 1'b1;
      if (fetch)       head_valid <= 1'b1;
      else if (retire) head_valid <= 1'b0;
    end
  end

  assign full             = (wr_count == FULL_CNT);
  assign bus.full         = full;
  assign bus.almost_full  = (wr_count >= AF_CNT);
  assign bus.prog_full    = (DEPTH - int'(wr_count)) < PROG_FULL_FREE;
  assign bus.wr_count     = wr_count;
  assign bus.err_overflow = err_overflow;
  assign bus.empty        = !head_valid;
  assign bus.dout         = head_valid ? subword : '0;
endmodule

// File: tb/tb_input_fifo_wconv.sv
// Bench for input_fifo_wconv: a 16->8 LSB-first instance checked against a
// word-queue reference model, and a 32->8 MSB-first instance checked directly.
module tb_input_fifo_wconv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_fifo_wconv_if #(.IN_WIDTH(16), .RATIO(2), .DEPTH_LOG2(4)) a_if ();
  input_fifo_wconv_if #(.IN_WIDTH(32), .RATIO(4), .DEPTH_LOG2(4)) b_if ();

  input_fifo_wconv #(
    .IN_WIDTH(16), .RATIO(2), .DEPTH_LOG2(4), .PROG_FULL_FREE(4), .LSB_FIRST(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

  input_fifo_wconv #(
    .IN_WIDTH(32), .RATIO(4), .DEPTH_LOG2(4), .PROG_FULL_FREE(4), .LSB_FIRST(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model for instance A: words in arrival order, each tagged with
  // the edge that stored it; a word becomes readable one edge after storage.
  typedef struct {
    logic [15:0] data;
    int          wedge;
  } word_t;
  word_t q[$];
  int    m_sub  = 0;
  bit    m_ovf  = 1'b0;
  int    edge_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string s);
    return $sformatf("%s@%0d", s, edge_n);
  endfunction

  function automatic bit a_visible();
    return (q.size() > 0) && (q[0].wedge < edge_n);
  endfunction

  task automatic model_reset();
    q.delete();
    m_sub = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_a();
    bit          vis;
    int          n;
    logic [7:0]  exp_dout;
    vis = a_visible();
    n   = q.size();
    exp_dout = vis ? 8'((q[0].data >> (8 * m_sub)) & 16'h00FF) : 8'h00;
    check(tg("a_empty"),        32'(a_if.empty),        32'(!vis));
    check(tg("a_dout"),         32'(a_if.dout),         32'(exp_dout));
    check(tg("a_wr_count"),     32'(a_if.wr_count),     32'(n));
    check(tg("a_full"),         32'(a_if.full),         32'(n == 16));
    check(tg("a_almost_full"),  32'(a_if.almost_full),  32'(n >= 15));
    check(tg("a_prog_full"),    32'(a_if.prog_full),    32'((16 - n) < 4));
    check(tg("a_err_overflow"), 32'(a_if.err_overflow), 32'(m_ovf));
  endtask

  task automatic step_a(input bit wr, input logic [15:0] d, input bit rd);
    bit wacc, racc;
    a_if.wr_en = wr;
    a_if.din   = d;
    a_if.rd_en = rd;
    wacc = wr && (q.size() < 16);
    racc = rd && a_visible();
    if (wr && !wacc) m_ovf = 1'b1;
    @(posedge clk);
    edge_n++;
    if (racc) begin
      if (m_sub == 1) begin
        void'(q.pop_front());
        m_sub = 0;
      end else begin
        m_sub++;
      end
    end
    if (wacc) q.push_back('{data: d, wedge: edge_n});
    #1;
    check_a();
  endtask

  task automatic step_b(input bit wr, input logic [31:0] d, input bit rd);
    b_if.wr_en = wr;
    b_if.din   = d;
    b_if.rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] pattern;
    int          gaps;
    bit          primed;

    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.din = '0;
    b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.din = '0;

    // Reset values, checked while reset is still held.
    #20;
    check_a();
    check("b_rst_empty", 32'(b_if.empty), 32'd1);
    check("b_rst_dout",  32'(b_if.dout),  32'd0);
    #2 rst = 1'b0;

    // MSB-first order on the 32->8 instance.
    step_b(1'b1, 32'hAABBCCDD, 1'b0);
    check("b_latency_empty", 32'(b_if.empty), 32'd1);
    step_b(1'b0, '0, 1'b0);
    check("b_msb0", 32'(b_if.dout), 32'hAA);
    step_b(1'b0, '0, 1'b1);
    check("b_msb1", 32'(b_if.dout), 32'hBB);
    step_b(1'b0, '0, 1'b1);
    check("b_msb2", 32'(b_if.dout), 32'hCC);
    step_b(1'b0, '0, 1'b1);
    check("b_msb3", 32'(b_if.dout), 32'hDD);
    step_b(1'b0, '0, 1'b1);
    check("b_drained", 32'(b_if.empty), 32'd1);
    for (int r = 0; r < 3; r++) begin
      w = $urandom;
      step_b(1'b1, w, 1'b0);
      step_b(1'b0, '0, 1'b0);
      for (int j = 0; j < 4; j++) begin
        check($sformatf("b_rand%0d_sub%0d", r, j), 32'(b_if.dout),
              (w >> (8 * (3 - j))) & 32'hFF);
        step_b(1'b0, '0, 1'b1);
      end
      check($sformatf("b_rand%0d_empty", r), 32'(b_if.empty), 32'd1);
    end

    // Basic write/read on instance A.
    step_a(1'b1, 16'h1234, 1'b0);
    step_a(1'b0, '0, 1'b0);
    check("basic_first", 32'(a_if.dout), 32'h34);
    step_a(1'b0, '0, 1'b1);
    check("basic_second", 32'(a_if.dout), 32'h12);
    step_a(1'b0, '0, 1'b1);
    check("basic_empty", 32'(a_if.empty), 32'd1);

    // Fill to 16 words, then a 17th write that must be dropped.
    for (int i = 1; i <= 17; i++) step_a(1'b1, 16'(16'hA000 + i), 1'b0);
    check("fill_overflow", 32'(a_if.err_overflow), 32'd1);
    check("fill_count",    32'(a_if.wr_count),     32'd16);

    // Full plus retire: the write coinciding with the retire is rejected.
    step_a(1'b0, '0, 1'b1);
    step_a(1'b1, 16'hBEEF, 1'b1);
    check("retire_reject", 32'(a_if.wr_count), 32'd15);
    step_a(1'b1, 16'hBEEF, 1'b0);
    check("retire_accept", 32'(a_if.wr_count), 32'd16);
    for (int i = 0; i < 40 && q.size() > 0; i++) step_a(1'b0, '0, 1'b1);
    check("fill_drained", 32'(a_if.empty), 32'd1);

    // Wrap streaming: one word every other cycle, one sub-word read per cycle.
    pattern = 16'h0100;
    gaps    = 0;
    primed  = 1'b0;
    for (int i = 0; i < 96; i++) begin
      step_a(i % 2 == 0, pattern, 1'b1);
      if (i % 2 == 0) pattern++;
      if (primed && a_if.empty) gaps++;
      if (!a_if.empty) primed = 1'b1;
    end
    check("stream_gaps", 32'(gaps), 32'd0);
    for (int i = 0; i < 8 && q.size() > 0; i++) step_a(1'b0, '0, 1'b1);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++)
      step_a($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 60);
    for (int i = 0; i < 40 && q.size() > 0; i++) step_a(1'b0, '0, 1'b1);

    // Reset in the middle of a word (sub-index 1).
    step_a(1'b1, 16'hC3D4, 1'b0);
    step_a(1'b0, '0, 1'b0);
    step_a(1'b0, '0, 1'b1);
    check("mid_sub1", 32'(a_if.dout), 32'hC3);
    #2 rst = 1'b1;
    #1;
    check("rst_empty",       32'(a_if.empty),        32'd1);
    check("rst_dout",        32'(a_if.dout),         32'd0);
    check("rst_wr_count",    32'(a_if.wr_count),     32'd0);
    check("rst_full",        32'(a_if.full),         32'd0);
    check("rst_almost_full", 32'(a_if.almost_full),  32'd0);
    check("rst_prog_full",   32'(a_if.prog_full),    32'd0);
    check("rst_overflow",    32'(a_if.err_overflow), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    step_a(1'b1, 16'h5A6B, 1'b0);
    step_a(1'b0, '0, 1'b0);
    check("post_rst_sub0", 32'(a_if.dout), 32'h6B);
    step_a(1'b0, '0, 1'b1);
    check("post_rst_sub1", 32'(a_if.dout), 32'h5A);
    step_a(1'b0, '0, 1'b1);
    check("post_rst_empty", 32'(a_if.empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
